regfile_multiport: RTL and testbench

- Parametrised successor to the core's 32x32 register file.
- Configurable register width, register count and number of read ports, with optional write-to-read bypass.
- Built-in clear sequencer: zeroes the array one entry per cycle after reset or on request, then loads one preset register (global pointer).
- Sits in decode stage; feeds operand muxes; written from writeback.

---
 rtl/regfile_multiport.sv | 125 ++++++++++++
 tb/tb_regfile_multiport.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_multiport.sv
// Multi-read-port register file with optional write-to-read bypass and a built-in
// clear sequencer that zeroes the array after reset or on request, then loads a preset.
module regfile_multiport #(
  parameter int              XLEN       = 32,
  parameter int              NREGS      = 32,
  parameter int              NRD        = 2,
  parameter bit              BYPASS     = 1'b1,
  parameter int              INIT_REG   = 3,
  parameter logic [XLEN-1:0] INIT_VALUE = XLEN'(32'h8000_0000),
  localparam int             AW         = $clog2(NREGS)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                write_enable,
  input  logic [AW-1:0]       rd_address,
  input  logic [XLEN-1:0]     rd_data,
  input  logic [NRD*AW-1:0]   rs_address,
  output logic [NRD*XLEN-1:0] rs_data,
  input  logic                clear_request,
  output logic                busy,
  output logic [1:0]          o_dbg_state
);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_LOAD  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
  localparam logic [AW-1:0] INIT_IDX = AW'(INIT_REG);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [AW-1:0]   r_idx;
  logic [AW-1:0]   w_idx_nxt;
  logic [XLEN-1:0] r_regs [NREGS];

  logic            w_user_we;
  logic            w_arr_we;
  logic [AW-1:0]   w_arr_addr;
  logic [XLEN-1:0] w_arr_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_CLEAR;
      r_idx   <= AW'(1);
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    unique case (r_state)
      ST_CLEAR: begin
        if (r_idx == LAST_IDX) w_state_nxt = ST_LOAD;
        else                   w_idx_nxt   = r_idx + 1'b1;
      end
      ST_LOAD:  w_state_nxt = ST_READY;
      ST_READY: begin
        if (clear_request) begin
          w_state_nxt = ST_CLEAR;
          w_idx_nxt   = AW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_CLEAR;
        w_idx_nxt   = AW'(1);
      end
    endcase
  end

  // A user write never lands while the sequencer owns the array or a clear is being requested.
  assign w_user_we = (r_state == ST_READY) && write_enable && !clear_request &&
                     (rd_address != '0) && (int'(rd_address) < NREGS);

  always_comb begin
    w_arr_we   = 1'b0;
    w_arr_addr = r_idx;
    w_arr_data = '0;
    unique case (r_state)
      ST_CLEAR: w_arr_we = 1'b1;
      ST_LOAD: begin
        w_arr_we   = (INIT_REG != 0);
        w_arr_addr = INIT_IDX;
        w_arr_data = INIT_VALUE;
      end
      ST_READY: begin
        w_arr_we   = w_user_we;
        w_arr_addr = rd_address;
        w_arr_data = rd_data;
      end
      default: w_arr_we = 1'b0;
    endcase
  end

  // Entry 0 is never written; its reads are forced to zero below.
  always_ff @(posedge clock) begin
    if (w_arr_we) r_regs[w_arr_addr] <= w_arr_data;
  end

  assign busy        = (r_state != ST_READY);
  assign o_dbg_state = r_state;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_port;

    assign w_ra = rs_address[k*AW +: AW];

    always_comb begin
      w_port = '0;
      if (!busy) begin
        if (BYPASS && w_user_we && (w_ra == rd_address)) w_port = rd_data;
        else if ((w_ra != '0) && (int'(w_ra) < NREGS))  w_port = r_regs[w_ra];
      end
    end

    assign rs_data[k*XLEN +: XLEN] = w_port;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: default, no-bypass and 64-bit/16-entry/3-port builds
// run side by side against a cycle-level reference model.
`timescale 1ns/1ps
module tb_regfile_multiport;

  localparam logic [31:0] INIT32 = 32'h8000_0000;
  localparam logic [63:0] WIDEV  = 64'hA5A5_0000_FFFF_0001;

  logic        clock;
  logic        reset_n;
  logic        write_enable;
  logic [4:0]  rd_address;
  logic [31:0] rd_data;
  logic [9:0]  rs_address;
  logic        clear_request;
  logic [63:0] rs_data_a;
  logic [63:0] rs_data_b;
  logic        busy_a;
  logic        busy_b;
  logic [1:0]  st_a;
  logic [1:0]  st_b;

  logic         w_write_enable;
  logic [3:0]   w_rd_address;
  logic [63:0]  w_rd_data;
  logic [11:0]  w_rs_address;
  logic [191:0] w_rs_data;
  logic         w_busy;
  logic [1:0]   st_w;

  logic [31:0] m_regs [32];
  int          m_busy;
  logic [63:0] mw_regs [16];
  int          mw_busy;

  logic [63:0] exp_q[$];
  int          n_checks;
  int          n_fail;

  regfile_multiport u_dut (
    .clock(clock), .reset_n(reset_n), .write_enable(write_enable),
    .rd_address(rd_address), .rd_data(rd_data), .rs_address(rs_address),
    .rs_data(rs_data_a), .clear_request(clear_request), .busy(busy_a), .o_dbg_state(st_a)
  );

  regfile_multiport #(.BYPASS(1'b0)) u_nb (
    .clock(clock), .reset_n(reset_n), .write_enable(write_enable),
    .rd_address(rd_address), .rd_data(rd_data), .rs_address(rs_address),
    .rs_data(rs_data_b), .clear_request(clear_request), .busy(busy_b), .o_dbg_state(st_b)
  );

  regfile_multiport #(.XLEN(64), .NREGS(16), .NRD(3)) u_w (
    .clock(clock), .reset_n(reset_n), .write_enable(w_write_enable),
    .rd_address(w_rd_address), .rd_data(w_rd_data), .rs_address(w_rs_address),
    .rs_data(w_rs_data), .clear_request(clear_request), .busy(w_busy), .o_dbg_state(st_w)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (!reset_n || m_busy != 0) return '0;
    if (a == 5'd0) return '0;
    if (byp && write_enable && !clear_request && rd_address == a) return rd_data;
    return m_regs[a];
  endfunction

  function automatic logic [63:0] exp_wrd(input logic [3:0] a);
    if (!reset_n || mw_busy != 0) return '0;
    if (a == 4'd0) return '0;
    if (w_write_enable && !clear_request && w_rd_address == a) return w_rd_data;
    return mw_regs[a];
  endfunction

  task automatic update_models();
    if (!reset_n) m_busy = 32;
    else if (m_busy != 0) begin
      m_busy--;
      if (m_busy == 0) begin
        foreach (m_regs[i]) m_regs[i] = '0;
        m_regs[3] = INIT32;
      end
    end
    else if (clear_request) m_busy = 32;
    else if (write_enable && rd_address != 5'd0) m_regs[rd_address] = rd_data;

    if (!reset_n) mw_busy = 16;
    else if (mw_busy != 0) begin
      mw_busy--;
      if (mw_busy == 0) begin
        foreach (mw_regs[i]) mw_regs[i] = '0;
        mw_regs[3] = 64'(INIT32);
      end
    end
    else if (clear_request) mw_busy = 16;
    else if (w_write_enable && w_rd_address != 4'd0) mw_regs[w_rd_address] = w_rd_data;
  endtask

  // Called just after a falling edge with inputs already applied.
  task automatic step();
    for (int k = 0; k < 2; k++) exp_q.push_back(64'(exp_rd(rs_address[k*5 +: 5], 1'b1)));
    for (int k = 0; k < 2; k++) exp_q.push_back(64'(exp_rd(rs_address[k*5 +: 5], 1'b0)));
    exp_q.push_back(64'(!reset_n || m_busy != 0));
    exp_q.push_back(64'(!reset_n || m_busy != 0));
    for (int k = 0; k < 3; k++) exp_q.push_back(exp_wrd(w_rs_address[k*4 +: 4]));
    exp_q.push_back(64'(!reset_n || mw_busy != 0));
    #1;
    for (int k = 0; k < 2; k++) check("rs_byp", 64'(rs_data_a[k*32 +: 32]), exp_q.pop_front());
    for (int k = 0; k < 2; k++) check("rs_nobyp", 64'(rs_data_b[k*32 +: 32]), exp_q.pop_front());
    check("busy_byp", 64'(busy_a), exp_q.pop_front());
    check("busy_nobyp", 64'(busy_b), exp_q.pop_front());
    for (int k = 0; k < 3; k++) check("rs_wide", w_rs_data[k*64 +: 64], exp_q.pop_front());
    check("busy_wide", 64'(w_busy), exp_q.pop_front());
    @(posedge clock);
    update_models();
    @(negedge clock);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    m_busy   = 32;
    mw_busy  = 16;
    foreach (m_regs[i]) m_regs[i] = '0;
    foreach (mw_regs[i]) mw_regs[i] = '0;

    reset_n        = 1'b0;
    write_enable   = 1'b1;
    rd_address     = 5'd5;
    rd_data        = 32'hDEAD;
    rs_address     = {5'd3, 5'd5};
    clear_request  = 1'b0;
    w_write_enable = 1'b0;
    w_rd_address   = 4'd0;
    w_rd_data      = '0;
    w_rs_address   = {4'd3, 4'd15, 4'd3};

    @(negedge clock);
    step();
    step();
    reset_n = 1'b1;
    repeat (32) step();
    write_enable = 1'b0;
    #1;
    check("busy_fall", 64'(busy_a), 64'd0);
    check("x5_dropped", 64'(rs_data_a[31:0]), 64'd0);
    check("x3_preset", 64'(rs_data_a[63:32]), 64'(INIT32));
    check("wide_x3_preset", w_rs_data[63:0], 64'(INIT32));
    step();

    write_enable   = 1'b1;
    rd_address     = 5'd7;
    rd_data        = 32'h1234_5678;
    rs_address     = {5'd7, 5'd7};
    w_write_enable = 1'b1;
    w_rd_address   = 4'd15;
    w_rd_data      = WIDEV;
    w_rs_address   = {4'd15, 4'd15, 4'd15};
    #1;
    check("byp_p0", 64'(rs_data_a[31:0]), 64'h1234_5678);
    check("byp_p1", 64'(rs_data_a[63:32]), 64'h1234_5678);
    check("nobyp_old", 64'(rs_data_b[31:0]), 64'd0);
    check("wide_byp_p2", w_rs_data[191:128], WIDEV);
    step();
    write_enable   = 1'b0;
    w_write_enable = 1'b0;
    #1;
    check("nobyp_new", 64'(rs_data_b[63:32]), 64'h1234_5678);
    check("wide_x15_p0", w_rs_data[63:0], WIDEV);
    step();

    write_enable = 1'b1;
    rd_address   = 5'd0;
    rd_data      = 32'hFFFF_FFFF;
    rs_address   = {5'd0, 5'd0};
    #1;
    check("x0_same_cycle", 64'(rs_data_a[31:0]), 64'd0);
    step();
    write_enable = 1'b0;
    #1;
    check("x0_next_cycle", 64'(rs_data_a[63:32]), 64'd0);
    step();

    for (int i = 1; i < 32; i++) begin
      write_enable   = 1'b1;
      rd_address     = 5'(i);
      rd_data        = 32'(i * 4);
      rs_address     = {5'(i - 1), 5'(i)};
      w_write_enable = 1'($urandom_range(0, 1));
      w_rd_address   = 4'($urandom_range(0, 15));
      w_rd_data      = {$urandom, $urandom};
      w_rs_address   = 12'($urandom);
      step();
    end

    for (int n = 0; n < 300; n++) begin
      write_enable   = 1'($urandom_range(0, 1));
      rd_address     = 5'($urandom_range(0, 31));
      rd_data        = $urandom;
      rs_address     = 10'($urandom);
      if ($urandom_range(0, 2) == 0) rs_address[4:0] = rd_address;
      w_write_enable = 1'($urandom_range(0, 1));
      w_rd_address   = 4'($urandom_range(0, 15));
      w_rd_data      = {$urandom, $urandom};
      w_rs_address   = 12'($urandom);
      if ($urandom_range(0, 2) == 0) w_rs_address[11:8] = w_rd_address;
      step();
    end

    clear_request  = 1'b1;
    write_enable   = 1'b1;
    rd_address     = 5'd9;
    rd_data        = 32'd1;
    rs_address     = {5'd9, 5'd9};
    w_write_enable = 1'b0;
    step();
    clear_request = 1'b0;
    write_enable  = 1'b0;
    repeat (32) step();
    rs_address = {5'd3, 5'd9};
    #1;
    check("x9_cleared", 64'(rs_data_a[31:0]), 64'd0);
    check("x3_after_clear", 64'(rs_data_a[63:32]), 64'(INIT32));
    for (int i = 0; i < 32; i++) begin
      rs_address   = {5'(31 - i), 5'(i)};
      w_rs_address = {4'(i), 4'(15 - i), 4'(i)};
      step();
    end

    clear_request = 1'b1;
    step();
    clear_request = 1'b0;
    repeat (9) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    repeat (32) step();
    #1;
    check("busy_after_reset_restart", 64'(busy_a), 64'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
